sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 144 ++++++++++++++
 tb/tb_sync_fifo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO with optional
//                rising-edge request detection, almost-full/almost-empty
//                thresholds, synchronous flush and sticky overflow/underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int FIFO_DATASIZE = 51,
  parameter int FIFO_ADDRSIZE = 2,
  parameter int PULSE_MODE    = 1,
  parameter int AF_TH         = (2 ** FIFO_ADDRSIZE) - 1,
  parameter int AE_TH         = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [FIFO_DATASIZE-1:0] wdata,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     pop,
  output logic [FIFO_DATASIZE-1:0] rdata,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [FIFO_ADDRSIZE:0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 2 ** FIFO_ADDRSIZE;

  localparam logic [FIFO_ADDRSIZE:0]   c_depth   = (FIFO_ADDRSIZE + 1)'(DEPTH);
  localparam logic [FIFO_ADDRSIZE:0]   c_af_th   = (FIFO_ADDRSIZE + 1)'(AF_TH);
  localparam logic [FIFO_ADDRSIZE:0]   c_ae_th   = (FIFO_ADDRSIZE + 1)'(AE_TH);
  localparam logic [FIFO_ADDRSIZE:0]   c_cnt_one = (FIFO_ADDRSIZE + 1)'(1);
  localparam logic [FIFO_ADDRSIZE-1:0] c_ptr_one = FIFO_ADDRSIZE'(1);

  // Storage is never cleared: pointers and count alone define validity.
  logic [FIFO_DATASIZE-1:0] r_mem [DEPTH];

  logic [FIFO_ADDRSIZE-1:0] r_wptr;
  logic [FIFO_ADDRSIZE-1:0] r_rptr;
  logic [FIFO_ADDRSIZE:0]   r_count;
  logic                     r_overflow;
  logic                     r_underflow;

  logic w_push_eff;
  logic w_pop_eff;
  logic w_wr_en;
  logic w_rd_en;

  // Request qualification: edge-detected or level-sensitive.
  if (PULSE_MODE != 0) begin : g_pulse
    logic r_push_q;
    logic r_pop_q;

    // Previous request levels; flush deliberately leaves these untouched so
    // a held request does not re-trigger after a flush.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_push_q <= 1'b0;
        r_pop_q  <= 1'b0;
      end else begin
        r_push_q <= push;
        r_pop_q  <= pop;
      end
    end

    assign w_push_eff = push & ~r_push_q;
    assign w_pop_eff  = pop  & ~r_pop_q;
  end else begin : g_level
    assign w_push_eff = push;
    assign w_pop_eff  = pop;
  end

  // Status flags come from the registered occupancy only.
  assign full         = (r_count == c_depth);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= c_af_th);
  assign almost_empty = (r_count <= c_ae_th);

  assign w_wr_en = w_push_eff & ~full  & ~flush;
  assign w_rd_en = w_pop_eff  & ~empty & ~flush;

  // Write port: store incoming data at the write pointer.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush takes priority over requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_rd_en) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: a rejected push/pop latches until flush or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_eff & full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop_eff & empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Head entry falls through combinationally; forced to zero when empty.
  assign rdata     = empty ? '0 : r_mem[r_rptr];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo
//  Description : Self-checking bench for sync_fifo. Three instances run side
//                by side (default edge mode, depth-2 level mode, depth-4
//                level mode) against a ring-buffer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int W = 51;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         flush  [N];
  logic         push   [N];
  logic         pop    [N];
  logic [W-1:0] wdata  [N];
  logic         dfull  [N];
  logic         daf    [N];
  logic         dempty [N];
  logic         dae    [N];
  logic         dovf   [N];
  logic         dunf   [N];
  logic [W-1:0] drdata [N];
  logic [2:0]   cnt0;
  logic [1:0]   cnt1;
  logic [2:0]   cnt2;

  sync_fifo u0 (
    .clk(clk), .rst(rst), .flush(flush[0]), .push(push[0]), .wdata(wdata[0]),
    .full(dfull[0]), .almost_full(daf[0]), .pop(pop[0]), .rdata(drdata[0]),
    .empty(dempty[0]), .almost_empty(dae[0]), .count(cnt0),
    .overflow(dovf[0]), .underflow(dunf[0])
  );

  sync_fifo #(.FIFO_ADDRSIZE(1), .PULSE_MODE(0)) u1 (
    .clk(clk), .rst(rst), .flush(flush[1]), .push(push[1]), .wdata(wdata[1]),
    .full(dfull[1]), .almost_full(daf[1]), .pop(pop[1]), .rdata(drdata[1]),
    .empty(dempty[1]), .almost_empty(dae[1]), .count(cnt1),
    .overflow(dovf[1]), .underflow(dunf[1])
  );

  sync_fifo #(.PULSE_MODE(0)) u2 (
    .clk(clk), .rst(rst), .flush(flush[2]), .push(push[2]), .wdata(wdata[2]),
    .full(dfull[2]), .almost_full(daf[2]), .pop(pop[2]), .rdata(drdata[2]),
    .empty(dempty[2]), .almost_empty(dae[2]), .count(cnt2),
    .overflow(dovf[2]), .underflow(dunf[2])
  );

  // Reference model: a ring of entries described by head index and occupancy.
  int           m_depth [N] = '{4, 2, 4};
  int           m_af    [N] = '{3, 1, 3};
  bit           m_pulse [N] = '{1'b1, 1'b0, 1'b0};
  logic [W-1:0] m_ring  [N][4];
  int           m_head  [N];
  int           m_cnt   [N];
  bit           m_pp    [N];
  bit           m_po    [N];
  bit           m_ovf   [N];
  bit           m_unf   [N];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] dut_cnt(int i);
    case (i)
      0:       return cnt0;
      1:       return {1'b0, cnt1};
      default: return cnt2;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_head[i] = 0; m_cnt[i] = 0;
      m_pp[i]   = 0; m_po[i]  = 0;
      m_ovf[i]  = 0; m_unf[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit pe, po, f, e, wr, rd;
      pe = m_pulse[i] ? (push[i] && !m_pp[i]) : push[i];
      po = m_pulse[i] ? (pop[i]  && !m_po[i]) : pop[i];
      if (flush[i]) begin
        m_head[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end else begin
        f  = (m_cnt[i] == m_depth[i]);
        e  = (m_cnt[i] == 0);
        wr = pe && !f;
        rd = po && !e;
        if (pe && f) m_ovf[i] = 1;
        if (po && e) m_unf[i] = 1;
        if (wr) m_ring[i][(m_head[i] + m_cnt[i]) % m_depth[i]] = wdata[i];
        if (rd) m_head[i] = (m_head[i] + 1) % m_depth[i];
        m_cnt[i] = m_cnt[i] + (wr ? 1 : 0) - (rd ? 1 : 0);
      end
      m_pp[i] = push[i];
      m_po[i] = pop[i];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      string s;
      logic [W-1:0] exp_rd;
      s = $sformatf("u%0d", i);
      exp_rd = (m_cnt[i] != 0) ? m_ring[i][m_head[i]] : '0;
      check_eq({s, ".count"}, dut_cnt(i), m_cnt[i]);
      check_eq({s, ".empty"}, dempty[i], m_cnt[i] == 0);
      check_eq({s, ".full"},  dfull[i],  m_cnt[i] == m_depth[i]);
      check_eq({s, ".afull"}, daf[i],    m_cnt[i] >= m_af[i]);
      check_eq({s, ".aempty"}, dae[i],   m_cnt[i] <= 1);
      check_eq({s, ".rdata"}, drdata[i], exp_rd);
      check_eq({s, ".ovf"},   dovf[i],   m_ovf[i]);
      check_eq({s, ".unf"},   dunf[i],   m_unf[i]);
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      flush[i] = 0; push[i] = 0; pop[i] = 0;
    end
  endtask

  task automatic pulse_push(int i, logic [W-1:0] d);
    push[i] = 1; wdata[i] = d; tick();
    push[i] = 0; tick();
  endtask

  task automatic pulse_pop(int i);
    pop[i] = 1; tick();
    pop[i] = 0; tick();
  endtask

  task automatic do_flush(int i);
    flush[i] = 1; tick();
    flush[i] = 0; tick();
  endtask

  initial begin
    logic [63:0] r64;
    rst = 1;
    idle_all();
    for (int i = 0; i < N; i++) wdata[i] = '0;
    model_reset();
    tick();
    tick();
    check_eq("rst.empty",  dempty[0], 1);
    check_eq("rst.aempty", dae[0],    1);
    check_eq("rst.full",   dfull[0],  0);
    check_eq("rst.rdata",  drdata[0], 0);
    rst = 0;
    tick();

    // Fill and drain in order.
    for (int k = 1; k <= 4; k++) begin
      pulse_push(0, W'(k));
      if (k == 3) check_eq("fill.af_after3", daf[0], 1);
    end
    check_eq("fill.count4", cnt0, 4);
    check_eq("fill.full",   dfull[0], 1);
    for (int k = 1; k <= 4; k++) begin
      check_eq("drain.head", drdata[0], k);
      pulse_pop(0);
    end
    check_eq("drain.empty", dempty[0], 1);
    check_eq("drain.rdata0", drdata[0], 0);

    // Overflow on a full FIFO, then flush.
    for (int k = 1; k <= 4; k++) pulse_push(0, W'(k));
    pulse_push(0, W'(5));
    check_eq("ovf.count", cnt0, 4);
    check_eq("ovf.flag", dovf[0], 1);
    tick();
    check_eq("ovf.sticky", dovf[0], 1);
    do_flush(0);
    check_eq("flush.count", cnt0, 0);
    check_eq("flush.ovf",   dovf[0], 0);
    check_eq("flush.empty", dempty[0], 1);

    // Simultaneous push and pop, partly filled and full.
    pulse_push(0, W'(17));
    pulse_push(0, W'(18));
    push[0] = 1; pop[0] = 1; wdata[0] = W'(10); tick();
    push[0] = 0; pop[0] = 0; tick();
    check_eq("simul.count", cnt0, 2);
    check_eq("simul.head",  drdata[0], 18);
    pulse_push(0, W'(19));
    pulse_push(0, W'(20));
    push[0] = 1; pop[0] = 1; wdata[0] = W'(21); tick();
    push[0] = 0; pop[0] = 0; tick();
    check_eq("fullsimul.count", cnt0, 3);
    check_eq("fullsimul.ovf",   dovf[0], 1);
    check_eq("fullsimul.head",  drdata[0], 10);
    do_flush(0);

    // Push held for five cycles: edge mode vs level mode.
    push[0] = 1; push[2] = 1;
    for (int k = 0; k < 5; k++) begin
      wdata[0] = W'(48 + k); wdata[2] = W'(48 + k); tick();
    end
    push[0] = 0; push[2] = 0; tick();
    check_eq("edge.u0count", cnt0, 1);
    check_eq("edge.u0head",  drdata[0], 48);
    check_eq("edge.u2count", cnt2, 4);
    check_eq("edge.u2full",  dfull[2], 1);
    check_eq("edge.u2ovf",   dovf[2], 1);
    flush[0] = 1; flush[2] = 1; tick();
    flush[0] = 0; flush[2] = 0; tick();

    // Pointer wrap in the depth-2 level-mode instance.
    push[1] = 1; wdata[1] = W'(256); tick();
    wdata[1] = W'(257); tick();
    push[1] = 0;
    for (int j = 0; j < 10; j++) begin
      check_eq("wrap.head", drdata[1], 256 + j);
      pop[1] = 1; tick();
      pop[1] = 0; push[1] = 1; wdata[1] = W'(258 + j); tick();
      push[1] = 0;
      check_eq("wrap.cnt_le2", cnt1 <= 2, 1);
    end
    check_eq("wrap.noovf", dovf[1], 0);
    pop[1] = 1; tick(); tick();
    pop[1] = 0; tick();

    // Push held high through reset release counts as an edge.
    push[0] = 1; wdata[0] = W'(119); rst = 1; model_reset();
    tick();
    rst = 0;
    tick();
    check_eq("rstrel.count", cnt0, 1);
    check_eq("rstrel.head",  drdata[0], 119);
    push[0] = 0; tick();

    // Asynchronous reset between edges with three entries stored.
    pulse_push(0, W'(129));
    pulse_push(0, W'(130));
    check_eq("arst.pre", cnt0, 3);
    #2;
    rst = 1; model_reset();
    #1;
    check_eq("arst.count", cnt0, 0);
    check_eq("arst.empty", dempty[0], 1);
    check_eq("arst.rdata", drdata[0], 0);
    tick();
    rst = 0;
    tick();

    // Randomized traffic on all instances.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        push[i]  = ($urandom_range(0, 99) < 55);
        pop[i]   = ($urandom_range(0, 99) < 45);
        flush[i] = ($urandom_range(0, 59) == 0);
        r64 = {$urandom(), $urandom()};
        wdata[i] = r64[W-1:0];
      end
      if (c == 800) begin
        rst = 1; model_reset();
      end else begin
        rst = 0;
      end
      tick();
    end
    rst = 0;
    idle_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
